// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scan/debounce front end
// Ports: none (package).
package keypad_pkg;
    localparam int KEY_W = 4;
    localparam int SEL_W = 3;
    localparam logic [KEY_W-1:0] NO_KEY = 4'hF;
    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;
endpackage

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: row-dwell divider and row select counter
// Ports: clk, rst_n (async active-low); sel = current row;
//        sample_en = last dwell cycle of a row; frame_end = sample_en on the last row.
import keypad_pkg::*;
module keypad_row_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int NUM_ROWS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [SEL_W-1:0] sel,
    output logic             sample_en,
    output logic             frame_end
);
    localparam int DW = $clog2(SCAN_DIV);
    logic [DW-1:0] div;
    // Sampling at the end of the dwell gives the decoder time to settle.
    assign sample_en = div == DW'(SCAN_DIV - 1);
    assign frame_end = sample_en && sel == SEL_W'(NUM_ROWS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            sel <= '0;
        end else if (sample_en) begin
            div <= '0;
            sel <= frame_end ? '0 : sel + SEL_W'(1);
        end else begin
            div <= div + DW'(1);
        end
    end
endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: keypad row scan, per-frame fold and frame-level debounce
// Ports: clk, rst_n (async active-low); press/scan_code from the key decoder;
//        sel = row select to the decoder; key_valid = one-cycle accept strobe;
//        key_code = last accepted key; key_held = accepted key still down.
import keypad_pkg::*;
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 1000,
    parameter int NUM_ROWS     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             press,
    input  logic [KEY_W-1:0] scan_code,
    output logic [SEL_W-1:0] sel,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_held
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CNT);
    logic             sample_en, frame_end, found, accept, rel_done;
    logic [KEY_W-1:0] acc, frame_code, cand, cand_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, rel_cnt, rel_nxt, cnt_inc, rel_inc;
    state_t           state, state_nxt;

    keypad_row_scanner #(.SCAN_DIV(SCAN_DIV), .NUM_ROWS(NUM_ROWS)) u_scan (
        .clk(clk), .rst_n(rst_n), .sel(sel), .sample_en(sample_en), .frame_end(frame_end)
    );

    // The last row's sample is folded in combinationally so the frame result
    // is ready in the same cycle that sample is taken.
    assign frame_code = found ? acc : (press ? scan_code : NO_KEY);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found <= 1'b0;
            acc   <= NO_KEY;
        end else if (frame_end) begin
            found <= 1'b0;
            acc   <= NO_KEY;
        end else if (sample_en && press && !found) begin
            found <= 1'b1;
            acc   <= scan_code;
        end
    end

    assign cnt_inc = cnt == CMAX ? cnt : cnt + CW'(1);
    assign rel_inc = rel_cnt == CMAX ? rel_cnt : rel_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= NO_KEY;
            cnt       <= '0;
            rel_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= NO_KEY;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            rel_cnt   <= rel_nxt;
            key_valid <= accept;
            key_code  <= accept ? cand_nxt : key_code;
            key_held  <= accept ? 1'b1 : (rel_done ? 1'b0 : key_held);
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        rel_nxt   = rel_cnt;
        if (frame_end) begin
            case (state)
                IDLE: if (frame_code != NO_KEY) begin
                    cand_nxt  = frame_code;
                    cnt_nxt   = CW'(1);
                    state_nxt = DEBOUNCE_CNT == 1 ? HELD : CONFIRM;
                end
                CONFIRM: if (frame_code == NO_KEY) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (frame_code != cand) begin
                    cand_nxt = frame_code;
                    cnt_nxt  = CW'(1);
                end else begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = cnt_inc == CMAX ? HELD : CONFIRM;
                end
                HELD: begin
                    // Any frame other than the held key, even another key, counts toward release.
                    rel_nxt = frame_code == key_code ? '0 : rel_inc;
                    if (rel_nxt == CMAX) begin
                        rel_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        accept   = frame_end && state != HELD && state_nxt == HELD;
        rel_done = frame_end && state == HELD && state_nxt == IDLE;
    end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: randomized and directed check of keypad_scan_debounce against a frame-level model
module tb_keypad_scan_debounce;
    localparam int SD = 4, NR = 4, DC = 3;
    localparam logic [15:0] NONE = 16'hFFFF;
    logic clk = 1'b0, rst_n = 1'b0, press, key_valid, key_held;
    logic [3:0] scan_code, key_code;
    logic [2:0] sel;
    logic [3:0] rk [4];
    logic [15:0] cur;
    int checks = 0, errors = 0;
    logic [3:0] hist [$];
    logic m_held, pend;
    logic [3:0] m_code;

    always #5 clk = ~clk;
    assign scan_code = rk[sel[1:0]];
    assign press = scan_code != 4'hF;

    keypad_scan_debounce #(.SCAN_DIV(SD), .NUM_ROWS(NR), .DEBOUNCE_CNT(DC)) dut (
        .clk(clk), .rst_n(rst_n), .press(press), .scan_code(scan_code),
        .sel(sel), .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function logic [15:0] rows_of(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function logic [3:0] fold(input logic [15:0] rows);
        for (int r = 0; r < NR; r++)
            if (rows[4*r +: 4] != 4'hF) return rows[4*r +: 4];
        return 4'hF;
    endfunction

    function bit last_match(input logic [3:0] k, input bit eq);
        if (hist.size() < DC) return 1'b0;
        for (int i = hist.size() - DC; i < hist.size(); i++)
            if ((hist[i] == k) != eq) return 1'b0;
        return 1'b1;
    endfunction

    task model_reset();
        hist.delete();
        m_held = 1'b0;
        m_code = 4'hF;
        pend = 1'b0;
    endtask

    task model_frame(input logic [3:0] fc);
        hist.push_back(fc);
        if (!m_held) begin
            if (fc != 4'hF && last_match(fc, 1'b1)) begin
                m_held = 1'b1;
                m_code = fc;
                pend = 1'b1;
                hist.delete();
            end
        end else if (last_match(m_code, 1'b0)) begin
            m_held = 1'b0;
            hist.delete();
        end
    endtask

    task run_frame(input logic [15:0] rows);
        for (int c = 0; c < 16; c++) begin
            chk("sel", 32'(sel), c / SD);
            chk("key_valid", 32'(key_valid), (c == 0) ? 32'(pend) : 32'd0);
            chk("key_code", 32'(key_code), 32'(m_code));
            chk("key_held", 32'(key_held), 32'(m_held));
            if (c == 0) begin
                pend = 1'b0;
                for (int r = 0; r < NR; r++) rk[r] = rows[4*r +: 4];
            end
            if (c == 15) model_frame(fold(rows));
            @(negedge clk);
        end
    endtask

    task frames(input logic [15:0] rows, input int n);
        repeat (n) run_frame(rows);
    endtask

    initial begin
        model_reset();
        for (int r = 0; r < NR; r++) rk[r] = 4'hF;
        repeat (5) @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 32'hF);
        chk("rst_held", 32'(key_held), 0);
        rst_n = 1'b1;
        frames(rows_of(4'hF, 4'hF, 4'h8, 4'hF), 13);
        chk("s2_code", 32'(key_code), 32'h8);
        chk("s2_held", 32'(key_held), 1);
        frames(NONE, 3);
        chk("s4_held", 32'(key_held), 0);
        chk("s4_code_kept", 32'(key_code), 32'h8);
        frames(rows_of(4'hF, 4'h9, 4'hF, 4'hF), 4);
        chk("s4_code", 32'(key_code), 32'h9);
        frames(NONE, 3);
        frames(rows_of(4'h2, 4'hF, 4'hF, 4'hF), 2);
        frames(NONE, 1);
        frames(rows_of(4'h2, 4'hF, 4'hF, 4'hF), 3);
        chk("s3_code", 32'(key_code), 32'h2);
        frames(NONE, 3);
        frames(rows_of(4'h1, 4'hF, 4'h8, 4'hF), 4);
        chk("s5_code", 32'(key_code), 32'h1);
        frames(rows_of(4'h0, 4'hF, 4'hF, 4'hF), 3);
        chk("s5_held", 32'(key_held), 0);
        chk("s5_no_roll", 32'(key_code), 32'h1);
        frames(rows_of(4'h0, 4'hF, 4'hF, 4'hF), 3);
        chk("s5_code0", 32'(key_code), 32'h0);
        frames(NONE, 3);
        cur = NONE;
        repeat (60) begin
            if ($urandom_range(0, 3) == 0)
                for (int r = 0; r < NR; r++)
                    cur[4*r +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            run_frame(cur);
        end
        frames(NONE, 4);
        frames(rows_of(4'hF, 4'h5, 4'hF, 4'hF), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_sel", 32'(sel), 0);
        chk("s6_valid", 32'(key_valid), 0);
        chk("s6_code", 32'(key_code), 32'hF);
        chk("s6_held", 32'(key_held), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frames(rows_of(4'hF, 4'h5, 4'hF, 4'hF), 2);
        chk("s6_no_early", 32'(key_held), 0);
        frames(rows_of(4'hF, 4'h5, 4'hF, 4'hF), 2);
        chk("s6_accept", 32'(key_code), 32'h5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
